trigger_frame_builder: RTL and testbench

- Packs a triggered 128-bit sample stream into framed AXI-Stream packets for the PL DDR MMU input (S_AXIS_0).
- Each frame is: one header line, 1..MAX_TRIGGER_LENGTH data lines, one footer line.
- Sits directly upstream of the DDR MMU, between the per-channel trigger logic and the MMU.

---
 rtl/trigger_frame_builder.sv | 250 +++++++++++++++++++++++++
 tb/tb_trigger_frame_builder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_frame_builder.sv
// trigger_frame_builder
// Packs a triggered 128-bit sample stream into framed AXI-Stream packets:
// one header line, 1..eff_max data lines, one footer line. A single output
// register feeds M_AXIS; the FSM only loads it when the slot is free, so a
// loaded line stays stable until the downstream side takes it.

module trigger_frame_builder #(
  parameter logic [7:0] CHANNEL_ID      = 8'd0,
  parameter int         TDATA_WIDTH     = 128,
  parameter int         TIMESTAMP_WIDTH = 48
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       SET_CONFIG,
  input  logic [15:0]                MAX_TRIGGER_LENGTH,
  input  logic [TDATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                       S_AXIS_tvalid,
  input  logic                       S_AXIS_tuser,
  output logic                       S_AXIS_tready,
  output logic [TDATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic                       M_AXIS_tvalid,
  output logic [TDATA_WIDTH/8-1:0]   M_AXIS_tkeep,
  output logic                       M_AXIS_tlast,
  input  logic                       M_AXIS_tready,
  output logic [15:0]                FRAME_COUNT,
  output logic [15:0]                TRUNC_COUNT
);

  localparam int KEEP_W  = TDATA_WIDTH / 8;
  localparam int HDR_PAD = TDATA_WIDTH - 16 - TIMESTAMP_WIDTH;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_HEADER     = 3'd1;
  localparam logic [2:0] ST_HOLD       = 3'd2;
  localparam logic [2:0] ST_DATA       = 3'd3;
  localparam logic [2:0] ST_FOOTER     = 3'd4;
  localparam logic [2:0] ST_WAIT_REARM = 3'd5;

  localparam logic [KEEP_W-1:0] KEEP_FULL   = {KEEP_W{1'b1}};
  localparam logic [KEEP_W-1:0] KEEP_FOOTER = {{(KEEP_W/2){1'b1}}, {(KEEP_W/2){1'b0}}};
  localparam logic [TDATA_WIDTH-1:0] FOOTER_LINE = {8'h55, {(TDATA_WIDTH-8){1'b1}}};

  // FSM and bookkeeping registers
  logic [2:0]                 state_q,     state_d;
  logic [15:0]                cfg_q,       cfg_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_q,        ts_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_lat_q,    ts_lat_d;
  logic [15:0]                eff_max_q,   eff_max_d;
  logic [15:0]                count_q,     count_d;
  logic                       trunc_q,     trunc_d;
  logic [TDATA_WIDTH-1:0]     hold_q,      hold_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic [15:0]                trunc_cnt_q, trunc_cnt_d;

  // Output line register
  logic [TDATA_WIDTH-1:0]     out_data_q,  out_data_d;
  logic [KEEP_W-1:0]          out_keep_q,  out_keep_d;
  logic                       out_last_q,  out_last_d;
  logic                       out_valid_q, out_valid_d;

  // Line-load request from the FSM to the output register
  logic                       load_en;
  logic [TDATA_WIDTH-1:0]     load_data;
  logic [KEEP_W-1:0]          load_keep;
  logic                       load_last;

  logic                       slot_free;
  logic                       s_ready;
  logic                       s_accept;
  logic [15:0]                cfg_clamped;
  logic [15:0]                count_inc;
  logic [TDATA_WIDTH-1:0]     header_line;

  // Helper terms shared by the FSM: output slot availability, clamped config, header image
  always_comb begin
    slot_free   = !out_valid_q || M_AXIS_tready;
    cfg_clamped = (cfg_q == 16'd0) ? 16'd1 : cfg_q;
    count_inc   = count_q + 16'd1;
    header_line = {8'hAA, CHANNEL_ID, ts_lat_q, {HDR_PAD{1'b0}}};
  end

  // Input-side ready per state; DATA only accepts when the beat can be forwarded at once
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ST_IDLE:       s_ready = 1'b1;
      ST_DATA:       s_ready = slot_free;
      ST_WAIT_REARM: s_ready = 1'b1;
      default:       s_ready = 1'b0;
    endcase
    s_accept = s_ready && S_AXIS_tvalid;
  end

  // Frame sequencing: decides next state, latches per-frame context and requests line loads
  always_comb begin
    state_d     = state_q;
    ts_lat_d    = ts_lat_q;
    eff_max_d   = eff_max_q;
    count_d     = count_q;
    trunc_d     = trunc_q;
    hold_d      = hold_q;
    frame_cnt_d = frame_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    load_en     = 1'b0;
    load_data   = '0;
    load_keep   = '0;
    load_last   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_accept && S_AXIS_tuser) begin
          hold_d    = S_AXIS_tdata;
          ts_lat_d  = ts_q;
          eff_max_d = cfg_clamped;
          count_d   = 16'd0;
          trunc_d   = 1'b0;
          state_d   = ST_HEADER;
        end
      end

      ST_HEADER: begin
        if (slot_free) begin
          load_en   = 1'b1;
          load_data = header_line;
          load_keep = KEEP_FULL;
          state_d   = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (slot_free) begin
          load_en   = 1'b1;
          load_data = hold_q;
          load_keep = KEEP_FULL;
          count_d   = 16'd1;
          if (eff_max_q == 16'd1) begin
            trunc_d = 1'b1;
            state_d = ST_FOOTER;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (s_accept) begin
          if (S_AXIS_tuser) begin
            load_en   = 1'b1;
            load_data = S_AXIS_tdata;
            load_keep = KEEP_FULL;
            count_d   = count_inc;
            if (count_inc == eff_max_q) begin
              trunc_d = 1'b1;
              state_d = ST_FOOTER;
            end
          end else begin
            trunc_d = 1'b0;
            state_d = ST_FOOTER;
          end
        end
      end

      ST_FOOTER: begin
        if (slot_free) begin
          load_en     = 1'b1;
          load_data   = FOOTER_LINE;
          load_keep   = KEEP_FOOTER;
          load_last   = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          trunc_cnt_d = trunc_cnt_q + {15'd0, trunc_q};
          state_d     = trunc_q ? ST_WAIT_REARM : ST_IDLE;
        end
      end

      ST_WAIT_REARM: begin
        if (s_accept && !S_AXIS_tuser) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register: a new line replaces the old one only when the FSM saw a free slot
  always_comb begin
    out_valid_d = out_valid_q && !M_AXIS_tready;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    if (load_en) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
      out_keep_d  = load_keep;
      out_last_d  = load_last;
    end
  end

  // Config capture and free-running timestamp
  always_comb begin
    cfg_d = SET_CONFIG ? MAX_TRIGGER_LENGTH : cfg_q;
    ts_d  = ts_q + TIMESTAMP_WIDTH'(1);
  end

  // State update with synchronous active-low reset; reset drops any frame in flight
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cfg_q       <= 16'd16;
      ts_q        <= '0;
      ts_lat_q    <= '0;
      eff_max_q   <= 16'd1;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      hold_q      <= '0;
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      ts_q        <= ts_d;
      ts_lat_q    <= ts_lat_d;
      eff_max_q   <= eff_max_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      hold_q      <= hold_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S_AXIS_tready = s_ready;
  assign M_AXIS_tdata  = out_data_q;
  assign M_AXIS_tvalid = out_valid_q;
  assign M_AXIS_tkeep  = out_keep_q;
  assign M_AXIS_tlast  = out_last_q;
  assign FRAME_COUNT   = frame_cnt_q;
  assign TRUNC_COUNT   = trunc_cnt_q;

endmodule

// File: tb/tb_trigger_frame_builder.sv
// tb_trigger_frame_builder
// Directed scenarios for trigger_frame_builder: each task drives a beat
// sequence, collects the emitted lines and compares them with frames the
// bench builds from hand-known formats.

module tb_trigger_frame_builder;

  logic         clk;
  logic         rst_n;
  logic         set_config;
  logic [15:0]  max_len;
  logic [127:0] s_tdata;
  logic         s_tvalid;
  logic         s_tuser;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic         m_tvalid;
  logic [15:0]  m_tkeep;
  logic         m_tlast;
  logic         m_tready;
  logic [15:0]  frame_count;
  logic [15:0]  trunc_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] HDR_EXP  = {8'hAA, 8'h3C, 48'h0, 64'h0};
  localparam logic [127:0] HDR_MASK = {16'hFFFF, 48'h0, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [127:0] FTR_EXP  = {8'h55, {120{1'b1}}};

  trigger_frame_builder #(.CHANNEL_ID(8'h3C)) dut (
    .CLK                (clk),
    .RESET_N            (rst_n),
    .SET_CONFIG         (set_config),
    .MAX_TRIGGER_LENGTH (max_len),
    .S_AXIS_tdata       (s_tdata),
    .S_AXIS_tvalid      (s_tvalid),
    .S_AXIS_tuser       (s_tuser),
    .S_AXIS_tready      (s_tready),
    .M_AXIS_tdata       (m_tdata),
    .M_AXIS_tvalid      (m_tvalid),
    .M_AXIS_tkeep       (m_tkeep),
    .M_AXIS_tlast       (m_tlast),
    .M_AXIS_tready      (m_tready),
    .FRAME_COUNT        (frame_count),
    .TRUNC_COUNT        (trunc_count)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // stimulus beats and collected / expected lines
  logic [127:0] in_data[$];
  logic         in_user[$];
  logic [127:0] got_data[$];
  logic [15:0]  got_keep[$];
  logic         got_last[$];
  logic [127:0] exp_data[$];
  logic [127:0] exp_mask[$];
  logic [15:0]  exp_keep[$];
  logic         exp_last[$];
  int           accepted_beats;
  int           stable_errs;

  function automatic logic [127:0] mk_data(input int i);
    logic [127:0] d;
    d = '0;
    for (int j = 0; j < 8; j++) d[16*j +: 16] = 16'(i + j);
    return d;
  endfunction

  task automatic add_beat(input int base, input logic user);
    in_data.push_back(mk_data(base));
    in_user.push_back(user);
  endtask

  task automatic exp_frame(input int first, input int n);
    exp_data.push_back(HDR_EXP); exp_mask.push_back(HDR_MASK);
    exp_keep.push_back(16'hFFFF); exp_last.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      exp_data.push_back(mk_data(first + k)); exp_mask.push_back({128{1'b1}});
      exp_keep.push_back(16'hFFFF); exp_last.push_back(1'b0);
    end
    exp_data.push_back(FTR_EXP); exp_mask.push_back({128{1'b1}});
    exp_keep.push_back(16'hFF00); exp_last.push_back(1'b1);
  endtask

  task automatic clear_all();
    in_data.delete(); in_user.delete();
    exp_data.delete(); exp_mask.delete(); exp_keep.delete(); exp_last.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; set_config = 1'b0; max_len = 16'd0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tdata = '0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_cfg(input logic [15:0] v);
    set_config = 1'b1; max_len = v;
    @(posedge clk); #1;
    set_config = 1'b0;
  endtask

  // Feeds in_data/in_user back to back, records every accepted output line.
  // mode 0: downstream always ready; mode 1: ready 1 cycle of every 3.
  task automatic run_stream(input int mode, input int max_cycles);
    int idx, cyc, idle;
    logic prev_stall;
    logic [127:0] prev_data;
    logic [15:0] prev_keep;
    logic prev_last;
    idx = 0; cyc = 0; idle = 0; prev_stall = 1'b0;
    prev_data = '0; prev_keep = '0; prev_last = 1'b0;
    got_data.delete(); got_keep.delete(); got_last.delete();
    accepted_beats = 0; stable_errs = 0;
    while ((idx < in_data.size() || idle < 8) && cyc < max_cycles) begin
      if (idx < in_data.size()) begin
        s_tvalid = 1'b1; s_tdata = in_data[idx]; s_tuser = in_user[idx];
      end else begin
        s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0;
      end
      m_tready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      @(negedge clk);
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data ||
                         m_tkeep !== prev_keep || m_tlast !== prev_last))
        stable_errs++;
      if (s_tvalid && s_tready) begin idx++; accepted_beats++; end
      if (m_tvalid && m_tready) begin
        got_data.push_back(m_tdata); got_keep.push_back(m_tkeep); got_last.push_back(m_tlast);
        idle = 0;
      end else begin
        idle++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata; prev_keep = m_tkeep; prev_last = m_tlast;
      @(posedge clk); #1;
      cyc++;
    end
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tdata = '0;
    checks++;
    if (cyc >= max_cycles) begin
      failures++;
      $display("[TB] FAIL stream_timeout cycles=%0d limit=%0d beats_left=%0d", cyc, max_cycles, in_data.size() - idx);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tdata !== '0) begin failures++; $display("[TB] FAIL rst_tdata got=%h exp=0", m_tdata); end
    checks++; if (m_tkeep !== 16'h0) begin failures++; $display("[TB] FAIL rst_tkeep got=%h exp=0", m_tkeep); end
    checks++; if (m_tlast !== 1'b0) begin failures++; $display("[TB] FAIL rst_tlast got=%b exp=0", m_tlast); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("[TB] FAIL rst_frame got=%0d exp=0", frame_count); end
    checks++; if (trunc_count !== 16'd0) begin failures++; $display("[TB] FAIL rst_trunc got=%0d exp=0", trunc_count); end
    checks++; if (s_tready !== 1'b1) begin failures++; $display("[TB] FAIL rst_s_tready got=%b exp=1", s_tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    do_reset(); clear_all();
    for (int i = 1; i <= 4; i++) add_beat(i, 1'b1);
    add_beat(200, 1'b0);
    exp_frame(1, 4);
    run_stream(0, 200);
    checks++;
    if (got_data.size() != exp_data.size()) begin failures++; $display("[TB] FAIL basic_lines got=%0d exp=%0d", got_data.size(), exp_data.size()); end
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
      checks++;
      if ((got_data[k] & exp_mask[k]) !== exp_data[k] || got_keep[k] !== exp_keep[k] || got_last[k] !== exp_last[k]) begin
        failures++;
        $display("[TB] FAIL basic_line%0d got=%h/%h/%b exp=%h/%h/%b", k, got_data[k], got_keep[k], got_last[k], exp_data[k], exp_keep[k], exp_last[k]);
      end
    end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("[TB] FAIL basic_frame got=%0d exp=1", frame_count); end
    checks++; if (trunc_count !== 16'd0) begin failures++; $display("[TB] FAIL basic_trunc got=%0d exp=0", trunc_count); end
  endtask

  task automatic test_truncation();
    do_reset(); set_cfg(16'd3); clear_all();
    for (int i = 1; i <= 10; i++) add_beat(i, 1'b1);
    add_beat(200, 1'b0);
    exp_frame(1, 3);
    run_stream(0, 200);
    checks++;
    if (got_data.size() != exp_data.size()) begin failures++; $display("[TB] FAIL trunc_lines got=%0d exp=%0d", got_data.size(), exp_data.size()); end
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
      checks++;
      if ((got_data[k] & exp_mask[k]) !== exp_data[k] || got_keep[k] !== exp_keep[k] || got_last[k] !== exp_last[k]) begin
        failures++;
        $display("[TB] FAIL trunc_line%0d got=%h/%h/%b exp=%h/%h/%b", k, got_data[k], got_keep[k], got_last[k], exp_data[k], exp_keep[k], exp_last[k]);
      end
    end
    checks++; if (accepted_beats != 11) begin failures++; $display("[TB] FAIL trunc_accepted got=%0d exp=11", accepted_beats); end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("[TB] FAIL trunc_frame got=%0d exp=1", frame_count); end
    checks++; if (trunc_count !== 16'd1) begin failures++; $display("[TB] FAIL trunc_trunc got=%0d exp=1", trunc_count); end
  endtask

  task automatic test_backpressure();
    do_reset(); clear_all();
    for (int i = 1; i <= 4; i++) add_beat(i, 1'b1);
    add_beat(200, 1'b0);
    exp_frame(1, 4);
    run_stream(1, 400);
    checks++;
    if (got_data.size() != exp_data.size()) begin failures++; $display("[TB] FAIL bp_lines got=%0d exp=%0d", got_data.size(), exp_data.size()); end
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
      checks++;
      if ((got_data[k] & exp_mask[k]) !== exp_data[k] || got_keep[k] !== exp_keep[k] || got_last[k] !== exp_last[k]) begin
        failures++;
        $display("[TB] FAIL bp_line%0d got=%h/%h/%b exp=%h/%h/%b", k, got_data[k], got_keep[k], got_last[k], exp_data[k], exp_keep[k], exp_last[k]);
      end
    end
    checks++; if (stable_errs != 0) begin failures++; $display("[TB] FAIL bp_stable unstable_cycles=%0d exp=0", stable_errs); end
    checks++; if (accepted_beats != 5) begin failures++; $display("[TB] FAIL bp_accepted got=%0d exp=5", accepted_beats); end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("[TB] FAIL bp_frame got=%0d exp=1", frame_count); end
  endtask

  task automatic test_config_zero();
    do_reset(); set_cfg(16'd0); clear_all();
    add_beat(1, 1'b1);
    add_beat(2, 1'b1);
    add_beat(201, 1'b0);
    add_beat(4, 1'b1);
    add_beat(202, 1'b0);
    exp_frame(1, 1);
    exp_frame(4, 1);
    run_stream(0, 200);
    checks++;
    if (got_data.size() != exp_data.size()) begin failures++; $display("[TB] FAIL cfg0_lines got=%0d exp=%0d", got_data.size(), exp_data.size()); end
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
      checks++;
      if ((got_data[k] & exp_mask[k]) !== exp_data[k] || got_keep[k] !== exp_keep[k] || got_last[k] !== exp_last[k]) begin
        failures++;
        $display("[TB] FAIL cfg0_line%0d got=%h/%h/%b exp=%h/%h/%b", k, got_data[k], got_keep[k], got_last[k], exp_data[k], exp_keep[k], exp_last[k]);
      end
    end
    checks++; if (frame_count !== 16'd2) begin failures++; $display("[TB] FAIL cfg0_frame got=%0d exp=2", frame_count); end
    checks++; if (trunc_count !== 16'd2) begin failures++; $display("[TB] FAIL cfg0_trunc got=%0d exp=2", trunc_count); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] ts_prev, ts_cur;
    do_reset(); clear_all();
    for (int f = 0; f < 10; f++) begin
      add_beat(10*f + 1, 1'b1);
      add_beat(10*f + 2, 1'b1);
      add_beat(300 + f, 1'b0);
      exp_frame(10*f + 1, 2);
    end
    run_stream(0, 400);
    checks++;
    if (got_data.size() != exp_data.size()) begin failures++; $display("[TB] FAIL b2b_lines got=%0d exp=%0d", got_data.size(), exp_data.size()); end
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
      checks++;
      if ((got_data[k] & exp_mask[k]) !== exp_data[k] || got_keep[k] !== exp_keep[k] || got_last[k] !== exp_last[k]) begin
        failures++;
        $display("[TB] FAIL b2b_line%0d got=%h/%h/%b exp=%h/%h/%b", k, got_data[k], got_keep[k], got_last[k], exp_data[k], exp_keep[k], exp_last[k]);
      end
    end
    if (got_data.size() >= 40) begin
      ts_prev = got_data[0][111:64];
      for (int f = 1; f < 10; f++) begin
        ts_cur = got_data[4*f][111:64];
        checks++;
        if (ts_cur !== ts_prev + 48'd6) begin
          failures++;
          $display("[TB] FAIL b2b_ts%0d got=%0d exp=%0d", f, ts_cur, ts_prev + 48'd6);
        end
        ts_prev = ts_cur;
      end
    end
    checks++; if (frame_count !== 16'd10) begin failures++; $display("[TB] FAIL b2b_frame got=%0d exp=10", frame_count); end
    checks++; if (trunc_count !== 16'd0) begin failures++; $display("[TB] FAIL b2b_trunc got=%0d exp=0", trunc_count); end
  endtask

  task automatic test_reset_mid_frame();
    int stray;
    do_reset(); clear_all();
    add_beat(40, 1'b1); add_beat(41, 1'b1); add_beat(210, 1'b0);
    run_stream(0, 200);
    checks++; if (frame_count !== 16'd1) begin failures++; $display("[TB] FAIL midrst_pre_frame got=%0d exp=1", frame_count); end
    s_tvalid = 1'b1; s_tuser = 1'b1; s_tdata = mk_data(50); m_tready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== mk_data(50)) begin failures++; $display("[TB] FAIL midrst_inflight got=%b/%h exp=1/%h", m_tvalid, m_tdata, mk_data(50)); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; s_tvalid = 1'b0; s_tuser = 1'b0; s_tdata = '0;
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tdata !== '0) begin failures++; $display("[TB] FAIL midrst_tdata got=%h exp=0", m_tdata); end
    checks++; if (m_tkeep !== 16'h0 || m_tlast !== 1'b0) begin failures++; $display("[TB] FAIL midrst_keeplast got=%h/%b exp=0/0", m_tkeep, m_tlast); end
    checks++; if (frame_count !== 16'd0 || trunc_count !== 16'd0) begin failures++; $display("[TB] FAIL midrst_counts got=%0d/%0d exp=0/0", frame_count, trunc_count); end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_tvalid) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("[TB] FAIL midrst_no_footer valid_cycles=%0d exp=0", stray); end
    @(posedge clk); #1;
    clear_all();
    add_beat(60, 1'b1); add_beat(61, 1'b1); add_beat(211, 1'b0);
    exp_frame(60, 2);
    run_stream(0, 200);
    checks++;
    if (got_data.size() != exp_data.size()) begin failures++; $display("[TB] FAIL midrst_lines got=%0d exp=%0d", got_data.size(), exp_data.size()); end
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
      checks++;
      if ((got_data[k] & exp_mask[k]) !== exp_data[k] || got_keep[k] !== exp_keep[k] || got_last[k] !== exp_last[k]) begin
        failures++;
        $display("[TB] FAIL midrst_line%0d got=%h/%h/%b exp=%h/%h/%b", k, got_data[k], got_keep[k], got_last[k], exp_data[k], exp_keep[k], exp_last[k]);
      end
    end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("[TB] FAIL midrst_frame got=%0d exp=1", frame_count); end
  endtask

  initial begin
    $display("[TB] starting trigger_frame_builder scenarios");
    test_reset();
    test_basic_frame();
    test_truncation();
    test_backpressure();
    test_config_zero();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
